dram_rout_deser: RTL and testbench

- Capture stage sitting directly downstream of the 16-core DRAM read pins (ROUT lines) and upstream of the AES core's RIO byte inputs.
- Samples the 16 serial ROUT bit streams on controller-issued bit strobes and assembles one byte per core.
- Presents all 16 bytes as a 128-bit word with a valid/ready handshake and a single-entry output buffer.
- Reports overruns and counts completed frames for bring-up debug.

---
 rtl/dram_rout_pkg.sv | 17 +
 rtl/rout_lane_shift.sv | 51 +++++
 rtl/dram_rout_deser.sv | 207 ++++++++++++++++++++
 tb/tb_dram_rout_deser.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_rout_pkg.sv
// dram_rout_pkg
//   Shared definitions for the DRAM ROUT capture stage: the frame-assembly
//   state encoding and the default lane geometry (16 cores, 8 bits each).
//   No ports; imported by dram_rout_deser and rout_lane_shift.
package dram_rout_pkg;

  localparam int NCORE_DEF = 16;
  localparam int BITS_DEF  = 8;
  localparam int LANE_W    = BITS_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rout_lane_shift.sv
// rout_lane_shift
//   One ROUT lane's serial-to-parallel shift register.
//   Ports:
//     clk, rst : clock and synchronous active-high reset
//     clr      : zero the register (new frame or discarded frame)
//     shift    : capture din as the next bit of the frame
//     din      : serial bit from this lane's ROUT line
//     lane     : assembled BITS-wide value
//   MSB_FIRST=1 shifts left so the first bit ends up in the MSB;
//   MSB_FIRST=0 shifts right so the first bit ends up in bit 0.
module rout_lane_shift
  import dram_rout_pkg::*;
#(
  parameter int BITS      = LANE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            shift,
  input  logic            din,
  output logic [BITS-1:0] lane
);

  logic [BITS-1:0] lane_q;
  logic [BITS-1:0] lane_d;

  always_comb begin
    lane_d = lane_q;
    if (clr) begin
      lane_d = '0;
    end else if (shift) begin
      if (MSB_FIRST) begin
        lane_d = {lane_q[BITS-2:0], din};
      end else begin
        lane_d = {din, lane_q[BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign lane = lane_q;

endmodule

// File: rtl/dram_rout_deser.sv
// dram_rout_deser
//   Capture stage between the 16-core DRAM ROUT pins and the AES RIO byte
//   inputs. Samples each ROUT line on controller bit strobes, assembles one
//   byte per core and hands the full word on through a single-entry buffer.
//   Ports:
//     CLK, RST       : clock, synchronous active-high reset
//     START          : pulse marking the start of a read frame
//     SAMPLE         : bit strobe, one pulse per bit position
//     ABORT          : discard the frame in progress (highest priority)
//     ROUT[NCORE]    : serial read data, bit k from core k+1
//     DRDY           : consumer ready; DATA_OUT taken when DVLD && DRDY
//     DATA_OUT       : lane k in [BITS*k +: BITS]
//     DVLD           : output buffer holds an unconsumed frame
//     BUSY           : frame assembly in progress (SHIFT or DONE)
//     OVERRUN        : sticky, a completed frame was dropped
//     FRAME_CNT      : frames loaded into the output buffer, wraps
module dram_rout_deser
  import dram_rout_pkg::*;
#(
  parameter int NCORE     = NCORE_DEF,
  parameter int BITS      = LANE_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IN_REG    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SAMPLE,
  input  logic                  ABORT,
  input  logic [NCORE-1:0]      ROUT,
  input  logic                  DRDY,
  output logic [NCORE*BITS-1:0] DATA_OUT,
  output logic                  DVLD,
  output logic                  BUSY,
  output logic                  OVERRUN,
  output logic [15:0]           FRAME_CNT
);

  localparam int IN_W  = NCORE + 3;
  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;

  logic [IN_W-1:0]       in_d;
  logic [IN_W-1:0]       in_s;
  logic                  abort_s;
  logic                  start_s;
  logic                  sample_s;
  logic [NCORE-1:0]      rout_s;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  lane_clr;
  logic                  lane_shift;
  logic                  xfer;
  logic [NCORE*BITS-1:0] word;

  logic [NCORE*BITS-1:0] data_q, data_d;
  logic                  dvld_q, dvld_d;
  logic                  ovr_q, ovr_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  // Optional input flop stage. Every control and data input goes through
  // the same stage, so their relative timing is preserved.
  always_comb begin
    in_d = {ABORT, START, SAMPLE, ROUT};
  end

  generate
    if (IN_REG) begin : g_in_reg
      logic [IN_W-1:0] in_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          in_q <= '0;
        end else begin
          in_q <= in_d;
        end
      end
      assign in_s = in_q;
    end else begin : g_in_bypass
      assign in_s = in_d;
    end
  endgenerate

  assign {abort_s, start_s, sample_s, rout_s} = in_s;

  // State register and bit counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. ABORT overrides everything; START always (re)opens a frame,
  // and beats a SAMPLE arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort_s) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (start_s) begin
            cnt_d = '0;
          end else if (sample_s) begin
            if (cnt_q == CNT_W'(BITS - 1)) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_d = start_s ? SHIFT : IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM outputs. A START in DONE clears the lanes on the same edge that
  // the transfer copies them, so the buffer still gets the finished word.
  always_comb begin
    lane_clr   = 1'b0;
    lane_shift = 1'b0;
    xfer       = 1'b0;
    if (abort_s) begin
      lane_clr = 1'b1;
    end else begin
      lane_clr   = start_s;
      lane_shift = (state_q == SHIFT) && sample_s && !start_s;
      xfer       = (state_q == DONE);
    end
  end

  generate
    for (genvar k = 0; k < NCORE; k++) begin : g_lane
      rout_lane_shift #(
        .BITS      (BITS),
        .MSB_FIRST (MSB_FIRST)
      ) u_lane (
        .clk   (CLK),
        .rst   (RST),
        .clr   (lane_clr),
        .shift (lane_shift),
        .din   (rout_s[k]),
        .lane  (word[BITS*k +: BITS])
      );
    end
  endgenerate

  // Single-entry output buffer. A load is allowed when the buffer is empty
  // or being drained this very cycle; otherwise the new frame is dropped.
  always_comb begin
    data_d      = data_q;
    dvld_d      = dvld_q;
    ovr_d       = ovr_q;
    frame_cnt_d = frame_cnt_q;
    if (xfer) begin
      if (!dvld_q || DRDY) begin
        data_d      = word;
        dvld_d      = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (dvld_q && DRDY) begin
      dvld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q      <= '0;
      dvld_q      <= 1'b0;
      ovr_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      data_q      <= data_d;
      dvld_q      <= dvld_d;
      ovr_q       <= ovr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign DATA_OUT  = data_q;
  assign DVLD      = dvld_q;
  assign OVERRUN   = ovr_q;
  assign FRAME_CNT = frame_cnt_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_dram_rout_deser.sv
// tb_dram_rout_deser
//   Drives two copies of dram_rout_deser from the same inputs: the default
//   build (MSB first, registered inputs) with a controllable DRDY, and an
//   LSB-first, unregistered-input build that always accepts. A frame-level
//   reference model predicts each buffer's contents, valid flag, overrun
//   flag and frame count.
module tb_dram_rout_deser;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sample = 1'b0;
  logic         abort = 1'b0;
  logic [15:0]  rout = '0;
  logic         drdy = 1'b0;
  logic         drdy2 = 1'b1;

  logic [127:0] data_out, data_out2;
  logic         dvld, dvld2, busy, busy2, overrun, overrun2;
  logic [15:0]  frame_cnt, frame_cnt2;

  int nAsserts = 0;
  int nFail    = 0;
  int cyc      = 0;

  // Reference model state
  logic [127:0] expData, exp2Data;
  logic         expDvld, expOverrun;
  logic [15:0]  expCnt, exp2Cnt;
  bit           active;
  int           nbits;
  logic [15:0]  frameBits [8];
  logic [15:0]  pat [8];
  bit           pendMain, pend2;
  int           pendMainEdge, pend2Edge, doneCyc;
  logic [127:0] pendMainWord, pend2Word;

  always #5 clk = ~clk;

  dram_rout_deser dut (
    .CLK(clk), .RST(rst), .START(start), .SAMPLE(sample), .ABORT(abort),
    .ROUT(rout), .DRDY(drdy), .DATA_OUT(data_out), .DVLD(dvld),
    .BUSY(busy), .OVERRUN(overrun), .FRAME_CNT(frame_cnt)
  );

  dram_rout_deser #(.MSB_FIRST(1'b0), .IN_REG(1'b0)) dut2 (
    .CLK(clk), .RST(rst), .START(start), .SAMPLE(sample), .ABORT(abort),
    .ROUT(rout), .DRDY(drdy2), .DATA_OUT(data_out2), .DVLD(dvld2),
    .BUSY(busy2), .OVERRUN(overrun2), .FRAME_CNT(frame_cnt2)
  );

  // Byte value of lane k is the k-th column of the sampled ROUT words,
  // read first-bit-first into either the MSB or the LSB end.
  function automatic logic [127:0] buildWord(input bit msbFirst);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 8; i++)
        w[8*k + (msbFirst ? 7 - i : i)] = frameBits[i][k];
    return w;
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".data"}, data_out, expData);
    checkVal({tag, ".dvld"}, 128'(dvld), 128'(expDvld));
    checkVal({tag, ".ovr"}, 128'(overrun), 128'(expOverrun));
    checkVal({tag, ".cnt"}, 128'(frame_cnt), 128'(expCnt));
    checkVal({tag, ".data2"}, data_out2, exp2Data);
    checkVal({tag, ".cnt2"}, 128'(frame_cnt2), 128'(exp2Cnt));
  endtask

  task automatic modelReset();
    expData = '0; exp2Data = '0; expDvld = 1'b0; expOverrun = 1'b0;
    expCnt = '0; exp2Cnt = '0; active = 1'b0; nbits = 0;
    pendMain = 1'b0; pend2 = 1'b0; doneCyc = -1;
  endtask

  task automatic applyReset();
    rst = 1'b1; start = 1'b0; sample = 1'b0; abort = 1'b0; rout = '0;
    repeat (2) @(posedge clk);
    modelReset();
    #1;
    rst = 1'b0;
    cyc += 2;
  endtask

  // Drive one cycle of inputs and advance the model through that edge.
  task automatic applyStimulus(input logic st, input logic sa, input logic ab,
                               input logic [15:0] ro, input logic dr);
    start = st; sample = sa; abort = ab; rout = ro; drdy = dr;
    if (ab && (pendMain || pend2) && doneCyc == cyc) begin
      pendMain = 1'b0;
      pend2    = 1'b0;
    end
    if (ab) begin
      active = 1'b0; nbits = 0;
    end else if (st) begin
      active = 1'b1; nbits = 0;
    end else if (sa && active) begin
      frameBits[nbits] = ro;
      nbits++;
      if (nbits == 8) begin
        pendMain = 1'b1; pendMainEdge = cyc + 2; pendMainWord = buildWord(1'b1);
        pend2 = 1'b1; pend2Edge = cyc + 1; pend2Word = buildWord(1'b0);
        doneCyc = cyc + 1;
        active = 1'b0; nbits = 0;
      end
    end
    @(posedge clk);
    if (pendMain && pendMainEdge == cyc) begin
      if (!expDvld || dr) begin
        expData = pendMainWord; expDvld = 1'b1; expCnt = expCnt + 16'd1;
      end else begin
        expOverrun = 1'b1;
      end
      pendMain = 1'b0;
    end else if (expDvld && dr) begin
      expDvld = 1'b0;
    end
    if (pend2 && pend2Edge == cyc) begin
      exp2Data = pend2Word; exp2Cnt = exp2Cnt + 16'd1; pend2 = 1'b0;
    end
    #1;
    cyc++;
  endtask

  task automatic step(input logic st, input logic sa, input logic ab,
                      input logic [15:0] ro, input logic dr, input string tag);
    applyStimulus(st, sa, ab, ro, dr);
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input logic dr, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, dr, tag);
  endtask

  task automatic setPatByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) pat[i] = v[7-i] ? 16'hFFFF : 16'h0000;
  endtask

  task automatic sendFrame(input logic dr, input string tag);
    step(1'b1, 1'b0, 1'b0, 16'h0, dr, tag);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, pat[i], dr, tag);
  endtask

  initial begin
    modelReset();
    applyReset();
    checkOutput("reset");
    checkVal("reset.busy", 128'(busy), 128'(0));

    $display("[TB] basic frame");
    setPatByte(8'hAA);
    sendFrame(1'b1, "basic");
    checkVal("basic.lat0", 128'(dvld), 128'(0));
    idle(1, 1'b1, "basic");
    checkVal("basic.lat1", 128'(dvld), 128'(0));
    idle(1, 1'b1, "basic");
    checkVal("basic.lat2", 128'(dvld), 128'(1));
    checkVal("basic.word", data_out, {16{8'hAA}});
    checkVal("basic.cnt1", 128'(frame_cnt), 128'(1));
    checkVal("basic.word2", data_out2, {16{8'h55}});
    idle(1, 1'b1, "basic");
    checkVal("basic.accept", 128'(dvld), 128'(0));

    $display("[TB] lane mapping");
    for (int i = 0; i < 8; i++) pat[i] = 16'h0000;
    pat[0] = 16'h0001;
    sendFrame(1'b1, "lanemap");
    idle(3, 1'b1, "lanemap");
    checkVal("lanemap.lsb", data_out2, 128'h01);
    checkVal("lanemap.msb", data_out, 128'h80);

    $display("[TB] backpressure");
    setPatByte(8'h11);
    sendFrame(1'b0, "bp");
    setPatByte(8'h22);
    sendFrame(1'b0, "bp");
    idle(4, 1'b0, "bp");
    checkVal("bp.keep", data_out, {16{8'h11}});
    checkVal("bp.ovr", 128'(overrun), 128'(1));
    checkVal("bp.dvld", 128'(dvld), 128'(1));
    idle(2, 1'b1, "bp_drain");
    checkVal("bp.drain", 128'(dvld), 128'(0));
    checkVal("bp.ovrsticky", 128'(overrun), 128'(1));

    $display("[TB] restart and abort");
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, "restart");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'($urandom), 1'b1, "restart");
    checkVal("restart.busy", 128'(busy), 128'(1));
    setPatByte(8'hFF);
    sendFrame(1'b1, "restart");
    idle(2, 1'b0, "restart");
    checkVal("restart.word", data_out, {16{8'hFF}});
    idle(1, 1'b1, "restart");
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, "abort");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'($urandom), 1'b0, "abort");
    step(1'b0, 1'b0, 1'b1, 16'h0, 1'b0, "abort");
    idle(3, 1'b0, "abort");
    checkVal("abort.busy", 128'(busy), 128'(0));
    setPatByte(8'h99);
    sendFrame(1'b1, "abortdone");
    step(1'b0, 1'b0, 1'b1, 16'h0, 1'b1, "abortdone");
    idle(3, 1'b1, "abortdone");
    checkVal("abortdone.busy", 128'(busy), 128'(0));

    $display("[TB] collisions");
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, "startsample");
    setPatByte(8'h3C);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, pat[i], 1'b1, "startsample");
    idle(2, 1'b0, "startsample");
    checkVal("startsample.word", data_out, {16{8'h3C}});
    setPatByte(8'h5A);
    sendFrame(1'b0, "loadacc");
    idle(3, 1'b0, "loadacc");
    setPatByte(8'hC3);
    sendFrame(1'b0, "loadacc");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "loadacc");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "loadacc");
    checkVal("loadacc.dvld", 128'(dvld), 128'(1));
    checkVal("loadacc.word", data_out, {16{8'hC3}});
    idle(2, 1'b1, "loadacc");

    $display("[TB] reset mid-frame");
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, "rstmid");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, "rstmid");
    applyReset();
    checkOutput("rstmid");
    checkVal("rstmid.data", data_out, 128'h0);
    checkVal("rstmid.ovr", 128'(overrun), 128'(0));
    checkVal("rstmid.cnt", 128'(frame_cnt), 128'(0));
    checkVal("rstmid.busy", 128'(busy), 128'(0));
    checkVal("rstmid.busy2", 128'(busy2), 128'(0));
    checkVal("rstmid.dvld2", 128'(dvld2), 128'(0));
    checkVal("rstmid.ovr2", 128'(overrun2), 128'(0));

    $display("[TB] frame count wrap");
    force dut.frame_cnt_q = 16'hFFFF;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    release dut.frame_cnt_q;
    expCnt = 16'hFFFF;
    checkOutput("wrap_pre");
    setPatByte(8'h81);
    sendFrame(1'b1, "wrap");
    idle(3, 1'b1, "wrap");
    checkVal("wrap.cnt0", 128'(frame_cnt), 128'(0));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 79) == 0, 16'($urandom),
           $urandom_range(0, 3) != 0, "random");
    end
    idle(4, 1'b1, "random_tail");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
